// File: rtl/hs_pkg.sv
// Shared helpers for the handshake arbiter: state encoding, clog2 and the
// round-robin winner search.
package hs_pkg;

  localparam int unsigned MAX_PORT = 16;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // First requester above 'last', wrapping modulo n; returns 'last' if none.
  function automatic int unsigned rr_pick(input logic [MAX_PORT-1:0] req,
                                          input int unsigned n,
                                          input int unsigned last);
    int unsigned idx;
    int unsigned win;
    logic        found;
    win   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_PORT; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && !found && req[idx[3:0]]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/hs_skid_rdy.sv
// Ready-registered skid stage: one-entry buffer, bypass when the registered
// ready is high, so upstream ready never depends combinationally on i_ready.
module hs_skid_rdy #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_rdy;
  logic         r_buf_vld;
  logic [W-1:0] r_buf;
  logic         w_store;

  // An accepted beat that downstream does not take this cycle is parked.
  assign w_store = i_valid & r_rdy & ~i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rdy     <= 1'b1;
      r_buf_vld <= 1'b0;
      r_buf     <= '0;
    end else begin
      r_rdy <= i_ready | (~r_buf_vld & ~w_store);
      if (w_store) begin
        r_buf_vld <= 1'b1;
        r_buf     <= i_data;
      end else if (r_buf_vld & i_ready) begin
        r_buf_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    o_ready = r_rdy;
    o_valid = r_buf_vld;
    o_data  = r_buf;
    if (r_rdy) begin
      o_valid = i_valid;
      o_data  = i_valid ? i_data : '0;
    end
  end

endmodule

// File: rtl/hs_rr_arb.sv
// Burst-granular round-robin arbiter merging NUM_PORT valid/ready streams
// onto one channel through a ready-registered skid stage.
module hs_rr_arb
  import hs_pkg::*;
#(
  parameter  int unsigned NUM_PORT  = 4,
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned IDW       = (clog2(NUM_PORT) > 1) ? clog2(NUM_PORT) : 32'd1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_PORT-1:0]       i_valid_up,
  output logic [NUM_PORT-1:0]       o_ready_up,
  input  logic [NUM_PORT*WIDTH-1:0] i_data_up,
  input  logic [NUM_PORT-1:0]       i_last_up,
  output logic                      o_valid_down,
  input  logic                      i_ready_down,
  output logic [WIDTH-1:0]          o_data_down,
  output logic                      o_last_down,
  output logic [IDW-1:0]            o_grant_id_down
);

  localparam int unsigned CNTW = (clog2(MAX_BURST) > 1) ? clog2(MAX_BURST) : 32'd1;
  localparam int unsigned SKW  = WIDTH + 1 + IDW;

  logic            r_state;
  logic            w_state_nxt;
  logic [IDW-1:0]  r_gnt;
  logic [IDW-1:0]  w_gnt_nxt;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  w_last_nxt;
  logic [CNTW-1:0] r_beat_cnt;
  logic [CNTW-1:0] w_beat_cnt_nxt;

  logic             w_skid_rdy;
  logic             w_sel_vld;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_accept;
  logic             w_release;
  logic             w_any_req;
  logic [IDW-1:0]   w_win_idle;
  logic [IDW-1:0]   w_win_rel;
  logic [SKW-1:0]   w_skid_out;

  assign w_any_req  = |i_valid_up;
  assign w_win_idle = IDW'(rr_pick(MAX_PORT'(i_valid_up), NUM_PORT, 32'(r_last)));
  // After a release the search starts just past the releasing owner.
  assign w_win_rel  = IDW'(rr_pick(MAX_PORT'(i_valid_up), NUM_PORT, 32'(r_gnt)));
  assign w_accept   = w_sel_vld & w_skid_rdy;
  assign w_release  = w_accept & (w_sel_last | (r_beat_cnt == CNTW'(MAX_BURST - 1)));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= ARB_IDLE;
      r_gnt      <= '0;
      r_last     <= IDW'(NUM_PORT - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next-state: grant, pointer and beat count
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_last_nxt     = r_last;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = ARB_BUSY;
          w_gnt_nxt      = w_win_idle;
          w_last_nxt     = w_win_idle;
          w_beat_cnt_nxt = '0;
        end
      end
      ARB_BUSY: begin
        if (w_release) begin
          w_beat_cnt_nxt = '0;
          if (w_any_req) begin
            w_gnt_nxt  = w_win_rel;
            w_last_nxt = w_win_rel;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + CNTW'(1);
        end
      end
    endcase
  end

  // Outputs: owner's ready and the selected upstream beat
  always_comb begin
    o_ready_up = '0;
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      if ((r_state == ARB_BUSY) && (IDW'(i) == r_gnt)) begin
        o_ready_up[i] = w_skid_rdy;
        w_sel_vld     = i_valid_up[i];
        w_sel_last    = i_last_up[i];
        w_sel_data    = i_data_up[i*WIDTH +: WIDTH];
      end
    end
  end

  hs_skid_rdy #(
    .W (SKW)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (w_sel_vld),
    .i_data    ({r_gnt, w_sel_last, w_sel_data}),
    .o_ready   (w_skid_rdy),
    .o_valid   (o_valid_down),
    .o_data    (w_skid_out),
    .i_ready   (i_ready_down)
  );

  assign {o_grant_id_down, o_last_down, o_data_down} = w_skid_out;

endmodule

// File: tb/tb_hs_rr_arb.sv
// Randomized bench for hs_rr_arb: a grant/pointer model plus an in-order
// scoreboard of accepted beats predicts every output each cycle.
module tb_hs_rr_arb;

  localparam int NP  = 4;
  localparam int W   = 32;
  localparam int MB  = 16;
  localparam int IDW = 2;
  localparam int NPH = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   vup;
  logic [NP-1:0]   rup;
  logic [NP*W-1:0] dup;
  logic [NP-1:0]   lup;
  logic            vd;
  logic            rd;
  logic [W-1:0]    dd;
  logic            ld;
  logic [IDW-1:0]  gd;

  always #5 clk = ~clk;

  hs_rr_arb #(
    .NUM_PORT  (NP),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_valid_up      (vup),
    .o_ready_up      (rup),
    .i_data_up       (dup),
    .i_last_up       (lup),
    .o_valid_down    (vd),
    .i_ready_down    (rd),
    .o_data_down     (dd),
    .o_last_down     (ld),
    .o_grant_id_down (gd)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           last;
    logic [W-1:0]   data;
  } beat_t;

  // Model: owner (-1 = nobody), last-granted pointer, beats in current burst,
  // registered upstream ready, and the in-order queue of accepted beats.
  beat_t sb[$];
  int    owner;
  int    ptr;
  int    cnt;
  bit    srdy;
  int    n_checks;
  int    n_fail;

  // cycles, valid %, last %, ready_down %, port mask
  int ph_cyc [NPH] = '{300, 300, 200, 300, 400, 300, 200};
  int ph_pv  [NPH] = '{ 60,  90, 100, 100,  50,  30, 100};
  int ph_pl  [NPH] = '{ 30,  50,   0,  50,  20,  10,  25};
  int ph_pr  [NPH] = '{100,  50, 100, 100,  30,  70,  60};
  int ph_msk [NPH] = '{ 15,  15,  12,  15,  15,  15,   3};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] req, input int from);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (from + k) % NP;
      if (((int'(req) >> p) & 1) != 0) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    ptr   = NP - 1;
    cnt   = 0;
    srdy  = 1'b1;
    sb.delete();
  endtask

  task automatic step_and_check();
    logic [NP-1:0] exp_rup;
    beat_t         b;
    beat_t         exp_b;
    bit            acc;
    int            w;
    exp_rup = '0;
    acc     = 1'b0;
    if (owner >= 0 && srdy) begin
      exp_rup = NP'(1) << owner;
      if (((int'(vup) >> owner) & 1) != 0) begin
        acc    = 1'b1;
        b.id   = IDW'(owner);
        b.last = ((int'(lup) >> owner) & 1) != 0;
        b.data = dup[owner*W +: W];
        sb.push_back(b);
      end
    end
    exp_b = (sb.size() > 0) ? sb[0] : '0;
    check_eq("ready_up",   64'(rup), 64'(exp_rup));
    check_eq("valid_down", 64'(vd),  64'(sb.size() > 0));
    check_eq("data_down",  64'(dd),  64'(exp_b.data));
    check_eq("last_down",  64'(ld),  64'(exp_b.last));
    check_eq("grant_id",   64'(gd),  64'(exp_b.id));

    if (sb.size() > 0 && rd) void'(sb.pop_front());
    srdy = rd || (sb.size() == 0);
    if (owner < 0) begin
      if (vup != '0) begin
        w     = pick(vup, ptr);
        owner = w;
        ptr   = w;
        cnt   = 0;
      end
    end else if (acc) begin
      if (b.last || cnt == MB - 1) begin
        w = pick(vup, owner);
        if (w >= 0) begin
          owner = w;
          ptr   = w;
        end else begin
          owner = -1;
        end
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    if (!rst_n) model_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    vup      = '0;
    lup      = '0;
    dup      = '0;
    rd       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int ph = 0; ph < NPH; ph++) begin
      for (int c = 0; c < ph_cyc[ph]; c++) begin
        rst_n = (c == 0) ? 1'b1 : ($urandom_range(0, 249) != 0);
        for (int p = 0; p < NP; p++) begin
          vup[p] = (((ph_msk[ph] >> p) & 1) != 0) && ($urandom_range(0, 99) < ph_pv[ph]);
          lup[p] = $urandom_range(0, 99) < ph_pl[ph];
          dup[p*W +: W] = $urandom;
        end
        rd = $urandom_range(0, 99) < ph_pr[ph];
        @(negedge clk);
        step_and_check();
        @(posedge clk);
        #1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
